// File: rtl/dm_access_unit_if.sv
// Bundle of all request, response and RAM-side signals of the MEM-stage data-memory access unit.
// Ports: req_* (pipeline request), rsp_* (response back to pipeline), mem_* (1-cycle sync RAM port).
// Modports: slave = the access unit itself, master = the environment (pipeline control plus RAM).
interface dm_access_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);

   logic                    req_valid;
   logic                    req_ready;
   logic                    req_we;
   logic [1:0]              req_size;
   logic                    req_signed;
   logic [ADDR_W-1:0]       req_addr;
   logic [DATA_W-1:0]       req_wdata;

   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [DATA_W-1:0]       rsp_rdata;
   logic                    rsp_err;

   logic                    mem_en;
   logic                    mem_we;
   logic [NB-1:0]           mem_be;
   logic [ADDR_W-OFF_W-1:0] mem_addr;
   logic [DATA_W-1:0]       mem_wdata;
   logic [DATA_W-1:0]       mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      input  rsp_ready,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      output rsp_ready,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dm_access_unit.sv
// Data-memory access unit: byte enables, two-beat split of word-crossing accesses, load extension.
// Latency from accept edge: error 1, aligned 3, split 4 cycles to rsp_valid; one access outstanding.
// Backpressure: req_ready only in IDLE; response held stable in RESP until rsp_ready.
// Ports: clk, reset (sync active-low), bus (dm_access_unit_if.slave: req_*, rsp_*, mem_*).
module dm_access_unit #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 32,
   parameter bit ALLOW_MISALIGN = 1'b1
) (
   input logic             clk,
   input logic             reset,
   dm_access_unit_if.slave bus
);
   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int WA_W  = ADDR_W - OFF_W;

   typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, CAPT, RESP} state_t;
   state_t state, state_nxt;

   // latched request
   logic              a_we;
   logic              a_signed;
   logic              a_split;
   logic [1:0]        a_size;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic [DATA_W-1:0] lo_rdata;

   logic              rsp_valid_q;
   logic              rsp_err_q;
   logic [DATA_W-1:0] rsp_rdata_q;

   logic accept;
   int   in_off, in_nb;
   logic in_split, in_err;

   assign bus.req_ready = (state == IDLE) && reset;
   assign accept        = bus.req_valid && bus.req_ready;

   // Decode of the incoming request; only used on the accept edge.
   always_comb begin
      in_off   = int'(bus.req_addr[OFF_W-1:0]);
      in_nb    = 1 << bus.req_size;
      in_split = (in_off + in_nb) > NB;
      in_err   = ((bus.req_size == 2'd3) && (DATA_W < 64)) ||
                 (((in_off % in_nb) != 0) && !ALLOW_MISALIGN);
   end

   // Datapath from latched request: a 2-word window covers both beats of a split access.
   int                  a_off, a_nb;
   logic [WA_W-1:0]     word_idx;
   logic [2*DATA_W-1:0] wr_win;
   logic [2*DATA_W-1:0] rd_win;
   logic [2*NB-1:0]     be_win;
   logic [DATA_W-1:0]   ld_val, ld_mask, ld_ext;
   logic                sign_bit;

   always_comb begin
      a_off    = int'(a_addr[OFF_W-1:0]);
      a_nb     = 1 << a_size;
      word_idx = a_addr[ADDR_W-1:OFF_W];
      wr_win   = {{DATA_W{1'b0}}, a_wdata} << (8 * a_off);
      be_win   = '0;
      for (int i = 0; i < NB; i++) begin
         if (i < a_nb) be_win[i] = 1'b1;
      end
      be_win = be_win << a_off;

      // In CAPT, mem_rdata holds the last beat; beat0 was parked in lo_rdata for splits.
      rd_win  = a_split ? {bus.mem_rdata, lo_rdata} : {{DATA_W{1'b0}}, bus.mem_rdata};
      rd_win  = rd_win >> (8 * a_off);
      ld_val  = rd_win[DATA_W-1:0];
      ld_mask = '0;
      sign_bit = 1'b0;
      for (int i = 0; i < NB; i++) begin
         if (i < a_nb) ld_mask[8*i +: 8] = 8'hFF;
         if (i == a_nb - 1) sign_bit = a_signed & ld_val[8*i + 7];
      end
      // full-word loads have an all-ones mask, so no extension happens
      ld_ext = (ld_val & ld_mask) | ({DATA_W{sign_bit}} & ~ld_mask);
   end

   // Next state and RAM port drive
   always_comb begin
      state_nxt     = state;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_be    = '0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = in_err ? RESP : BEAT0;
         end
         BEAT0: begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = a_we;
            bus.mem_be    = be_win[NB-1:0];
            bus.mem_addr  = word_idx;
            bus.mem_wdata = wr_win[DATA_W-1:0];
            state_nxt     = a_split ? BEAT1 : CAPT;
         end
         BEAT1: begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = a_we;
            bus.mem_be    = be_win[2*NB-1:NB];
            bus.mem_addr  = word_idx + WA_W'(1);   // wraps at the top of the word space
            bus.mem_wdata = wr_win[2*DATA_W-1:DATA_W];
            state_nxt     = CAPT;
         end
         CAPT: state_nxt = RESP;
         RESP: begin
            if (bus.rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         a_we        <= 1'b0;
         a_signed    <= 1'b0;
         a_split     <= 1'b0;
         a_size      <= 2'd0;
         a_addr      <= '0;
         a_wdata     <= '0;
         lo_rdata    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (accept) begin
                  a_we     <= bus.req_we;
                  a_signed <= bus.req_signed;
                  a_size   <= bus.req_size;
                  a_addr   <= bus.req_addr;
                  a_wdata  <= bus.req_wdata;
                  a_split  <= in_split && !in_err;
                  if (in_err) begin
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                  end
               end
            end
            BEAT1: lo_rdata <= bus.mem_rdata;
            CAPT: begin
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= a_we ? '0 : ld_ext;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dm_access_unit.sv
module tb_dm_access_unit;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dm_access_unit_if #(.DATA_W(32), .ADDR_W(32)) bus ();
   dm_access_unit_if #(.DATA_W(32), .ADDR_W(32)) bus_na ();

   dm_access_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(1'b1)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   dm_access_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(1'b0)) dut_na (
      .clk(clk), .reset(reset), .bus(bus_na)
   );

   int checks = 0;
   int errors = 0;

   // RAM model with 1-cycle read latency
   logic [31:0] ram [0:15];
   logic        ram_init = 1'b0;
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
         ram[0] <= 32'h44332211;
         ram[1] <= 32'h88776655;
      end else if (bus.mem_en) begin
         if (bus.mem_we) begin
            for (int i = 0; i < 4; i++)
               if (bus.mem_be[i]) ram[bus.mem_addr[3:0]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
         end
         bus.mem_rdata <= ram[bus.mem_addr[3:0]];
      end
   end

   // beat log
   logic [29:0] log_addr[$];
   logic [3:0]  log_be[$];
   logic [31:0] log_wd[$];
   logic        log_we[$];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         log_addr.push_back(bus.mem_addr);
         log_be.push_back(bus.mem_be);
         log_wd.push_back(bus.mem_wdata);
         log_we.push_back(bus.mem_we);
      end
   end

   int na_mem_cnt = 0;
   always @(posedge clk) if (bus_na.mem_en) na_mem_cnt <= na_mem_cnt + 1;

   task automatic init_ram();
      @(negedge clk) ram_init = 1'b1;
      @(negedge clk) ram_init = 1'b0;
   endtask

   // Drive one request on bus; return number of edges from accept to rsp_valid (-1 on timeout).
   task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output int base);
      @(negedge clk);
      base = log_addr.size();
      bus.req_we = we; bus.req_size = size; bus.req_signed = sgn;
      bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
      @(posedge clk);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) bus.req_valid = 1'b0;
         if (bus.rsp_valid) begin lat = k; break; end
      end
   endtask

   task automatic complete();
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_hs got %b want 1", bus.req_ready); end
   endtask

   task automatic issue_na(input logic [1:0] size, input logic [31:0] addr, output int lat);
      @(negedge clk);
      bus_na.req_we = 1'b0; bus_na.req_size = size; bus_na.req_signed = 1'b0;
      bus_na.req_addr = addr; bus_na.req_wdata = 32'h0; bus_na.req_valid = 1'b1;
      @(posedge clk);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) bus_na.req_valid = 1'b0;
         if (bus_na.rsp_valid) begin lat = k; break; end
      end
   endtask

   task automatic complete_na();
      bus_na.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_na.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", bus.rsp_valid); end
      checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got %b want 0", bus.rsp_err); end
      checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata got %h want 0", bus.rsp_rdata); end
      checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %b want 0", bus.mem_en); end
      checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b want 0", bus.mem_we); end
      checks++; if (bus.mem_be !== 4'h0) begin errors++; $display("FAIL rst_mem_be got %b want 0000", bus.mem_be); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b want 0", bus.req_ready); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_req_ready got %b want 1", bus.req_ready); end
   endtask

   task automatic test_load_byte();
      int lat, base;
      issue(1'b0, 2'd0, 1'b1, 32'h7, 32'h0, lat, base);
      checks++; if (lat !== 3) begin errors++; $display("FAIL lb_s_lat got %0d want 3", lat); end
      checks++; if (bus.rsp_rdata !== 32'hFFFFFF88) begin errors++; $display("FAIL lb_s_data got %h want ffffff88", bus.rsp_rdata); end
      checks++; if (log_addr.size() - base !== 1) begin errors++; $display("FAIL lb_beats got %0d want 1", log_addr.size() - base); end
      checks++; if (log_be[base] !== 4'b1000) begin errors++; $display("FAIL lb_be got %b want 1000", log_be[base]); end
      checks++; if (log_addr[base] !== 30'd1) begin errors++; $display("FAIL lb_addr got %h want 1", log_addr[base]); end
      checks++; if (log_we[base] !== 1'b0) begin errors++; $display("FAIL lb_we got %b want 0", log_we[base]); end
      complete();
      issue(1'b0, 2'd0, 1'b0, 32'h7, 32'h0, lat, base);
      checks++; if (bus.rsp_rdata !== 32'h00000088) begin errors++; $display("FAIL lb_u_data got %h want 00000088", bus.rsp_rdata); end
      checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL lb_u_err got %b want 0", bus.rsp_err); end
      complete();
   endtask

   task automatic test_load_half();
      int lat, base;
      issue(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, lat, base);
      checks++; if (lat !== 4) begin errors++; $display("FAIL lh_split_lat got %0d want 4", lat); end
      checks++; if (bus.rsp_rdata !== 32'h00005544) begin errors++; $display("FAIL lh_split_data got %h want 00005544", bus.rsp_rdata); end
      checks++; if (log_addr.size() - base !== 2) begin errors++; $display("FAIL lh_beats got %0d want 2", log_addr.size() - base); end
      checks++; if (log_addr[base] !== 30'd0 || log_be[base] !== 4'b1000) begin errors++; $display("FAIL lh_beat0 got %h/%b want 0/1000", log_addr[base], log_be[base]); end
      checks++; if (log_addr[base+1] !== 30'd1 || log_be[base+1] !== 4'b0001) begin errors++; $display("FAIL lh_beat1 got %h/%b want 1/0001", log_addr[base+1], log_be[base+1]); end
      complete();
      issue(1'b0, 2'd1, 1'b1, 32'h6, 32'h0, lat, base);
      checks++; if (lat !== 3) begin errors++; $display("FAIL lh_s_lat got %0d want 3", lat); end
      checks++; if (bus.rsp_rdata !== 32'hFFFF8877) begin errors++; $display("FAIL lh_s_data got %h want ffff8877", bus.rsp_rdata); end
      checks++; if (log_be[base] !== 4'b1100) begin errors++; $display("FAIL lh_s_be got %b want 1100", log_be[base]); end
      complete();
   endtask

   task automatic test_load_word();
      int lat, base;
      issue(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, lat, base);
      checks++; if (lat !== 4) begin errors++; $display("FAIL lw_split_lat got %0d want 4", lat); end
      checks++; if (bus.rsp_rdata !== 32'h66554433) begin errors++; $display("FAIL lw_split_data got %h want 66554433", bus.rsp_rdata); end
      checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL lw_split_err got %b want 0", bus.rsp_err); end
      complete();
      issue(1'b0, 2'd2, 1'b1, 32'h4, 32'h0, lat, base);
      checks++; if (lat !== 3) begin errors++; $display("FAIL lw_al_lat got %0d want 3", lat); end
      checks++; if (bus.rsp_rdata !== 32'h88776655) begin errors++; $display("FAIL lw_al_data got %h want 88776655", bus.rsp_rdata); end
      checks++; if (log_be[base] !== 4'b1111) begin errors++; $display("FAIL lw_al_be got %b want 1111", log_be[base]); end
      complete();
   endtask

   task automatic test_store();
      int lat, base;
      issue(1'b1, 2'd2, 1'b0, 32'h1, 32'hDEADBEEF, lat, base);
      checks++; if (lat !== 4) begin errors++; $display("FAIL sw_lat got %0d want 4", lat); end
      checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL sw_rdata got %h want 0", bus.rsp_rdata); end
      checks++; if (log_addr.size() - base !== 2) begin errors++; $display("FAIL sw_beats got %0d want 2", log_addr.size() - base); end
      checks++; if (log_addr[base] !== 30'd0 || log_be[base] !== 4'b1110 || log_wd[base] !== 32'hADBEEF00 || log_we[base] !== 1'b1)
         begin errors++; $display("FAIL sw_beat0 got %h/%b/%h/%b want 0/1110/adbeef00/1", log_addr[base], log_be[base], log_wd[base], log_we[base]); end
      checks++; if (log_addr[base+1] !== 30'd1 || log_be[base+1] !== 4'b0001 || log_wd[base+1][7:0] !== 8'hDE || log_we[base+1] !== 1'b1)
         begin errors++; $display("FAIL sw_beat1 got %h/%b/%h/%b want 1/0001/000000de/1", log_addr[base+1], log_be[base+1], log_wd[base+1], log_we[base+1]); end
      complete();
      issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, lat, base);
      checks++; if (bus.rsp_rdata !== 32'hADBEEF11) begin errors++; $display("FAIL sw_readback0 got %h want adbeef11", bus.rsp_rdata); end
      complete();
      issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, lat, base);
      checks++; if (bus.rsp_rdata !== 32'h887766DE) begin errors++; $display("FAIL sw_readback1 got %h want 887766de", bus.rsp_rdata); end
      complete();
   endtask

   task automatic test_wrap_and_illegal();
      int lat, base;
      issue(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, lat, base);
      checks++; if (log_addr[base] !== 30'h3FFFFFFF || log_addr[base+1] !== 30'h0) begin errors++; $display("FAIL wrap_addr got %h,%h want 3fffffff,0", log_addr[base], log_addr[base+1]); end
      checks++; if (bus.rsp_rdata !== 32'h22110000) begin errors++; $display("FAIL wrap_data got %h want 22110000", bus.rsp_rdata); end
      complete();
      issue(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, lat, base);
      checks++; if (lat !== 1) begin errors++; $display("FAIL size3_lat got %0d want 1", lat); end
      checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL size3_rsp got %b/%h want 1/0", bus.rsp_err, bus.rsp_rdata); end
      checks++; if (log_addr.size() - base !== 0) begin errors++; $display("FAIL size3_beats got %0d want 0", log_addr.size() - base); end
      complete();
   endtask

   task automatic test_no_misalign();
      int lat;
      issue_na(2'd1, 32'h1, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL na_lh_lat got %0d want 1", lat); end
      checks++; if (bus_na.rsp_err !== 1'b1 || bus_na.rsp_rdata !== 32'h0) begin errors++; $display("FAIL na_lh_rsp got %b/%h want 1/0", bus_na.rsp_err, bus_na.rsp_rdata); end
      complete_na();
      issue_na(2'd3, 32'h0, lat);
      checks++; if (lat !== 1 || bus_na.rsp_err !== 1'b1) begin errors++; $display("FAIL na_size3 got lat %0d err %b want 1/1", lat, bus_na.rsp_err); end
      complete_na();
      checks++; if (na_mem_cnt !== 0) begin errors++; $display("FAIL na_mem_en got %0d beats want 0", na_mem_cnt); end
      issue_na(2'd0, 32'h1, lat);
      checks++; if (lat !== 3 || bus_na.rsp_rdata !== 32'h000000F0 || bus_na.rsp_err !== 1'b0)
         begin errors++; $display("FAIL na_lb got lat %0d data %h err %b want 3/000000f0/0", lat, bus_na.rsp_rdata, bus_na.rsp_err); end
      complete_na();
   endtask

   task automatic test_backpressure();
      int lat, base;
      issue(1'b0, 2'd0, 1'b0, 32'h5, 32'h0, lat, base);
      checks++; if (lat !== 3) begin errors++; $display("FAIL bp_lat got %0d want 3", lat); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h66 || bus.req_ready !== 1'b0)
            begin errors++; $display("FAIL bp_hold%0d got v%b d%h r%b want v1 d00000066 r0", c, bus.rsp_valid, bus.rsp_rdata, bus.req_ready); end
      end
      complete();
   endtask

   task automatic test_reset_mid_beat();
      int lat, base;
      @(negedge clk);
      bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_signed = 1'b0;
      bus.req_addr = 32'h2; bus.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk) bus.req_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 30'd1) begin errors++; $display("FAIL mid_beat1 got en %b addr %h want 1/1", bus.mem_en, bus.mem_addr); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (bus.mem_en !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0)
         begin errors++; $display("FAIL mid_rst got en %b v %b r %b want 0/0/0", bus.mem_en, bus.rsp_valid, bus.req_ready); end
      reset = 1'b1;
      issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, lat, base);
      checks++; if (lat !== 3 || bus.rsp_rdata !== 32'h88776655) begin errors++; $display("FAIL post_rst_lw got lat %0d data %h want 3/88776655", lat, bus.rsp_rdata); end
      complete();
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
      bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b0;
      bus_na.req_valid = 1'b0; bus_na.req_we = 1'b0; bus_na.req_size = 2'd0; bus_na.req_signed = 1'b0;
      bus_na.req_addr = 32'h0; bus_na.req_wdata = 32'h0; bus_na.rsp_ready = 1'b0;
      bus_na.mem_rdata = 32'hCAFEF00D;
      test_reset();
      init_ram();
      test_load_byte();
      test_load_half();
      test_load_word();
      test_store();
      init_ram();
      test_wrap_and_illegal();
      test_no_misalign();
      test_backpressure();
      init_ram();
      test_reset_mid_beat();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
